// File: rtl/spi_key_if.sv
// Pin-side and result-side signals of the keyboard SPI link, bundled for the receiver.
// The master modport is the side that drives the SPI pins and observes the results.
interface spi_key_if #(
    parameter int FRAME_BITS = 8
);
    logic                  key_sck;
    logic                  key_mosi;
    logic                  key_cs_n;
    logic [FRAME_BITS-1:0] key;
    logic                  key_strobe;
    logic                  frame_err;
    logic                  busy;
    logic [1:0]            dbg_state;

    modport master (
        output key_sck, key_mosi, key_cs_n,
        input  key, key_strobe, frame_err, busy, dbg_state
    );

    modport slave (
        input  key_sck, key_mosi, key_cs_n,
        output key, key_strobe, frame_err, busy, dbg_state
    );
endinterface

// File: rtl/spi_key_receiver.sv
// Oversampled SPI mode-0 slave that captures 8-bit key codes from the keyboard MCU.
// No logic runs on sck; all pins pass through synchronizers and edge detectors on clk.
module spi_key_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FRAME_BITS     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    spi_key_if.slave   spi
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BITS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // dbg_state exposes the encoding below: IDLE=0, SHIFT=1, ERR=2.
    // The frame handshake is cs_n framing only: a frame is accepted when cs_n rises after
    // exactly FRAME_BITS sck rises; key_strobe then marks the one cycle key was updated.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ERR   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    state_t                 r_state;
    logic [CW-1:0]          r_bit_cnt;
    logic [TW-1:0]          r_timer;
    logic [FRAME_BITS-1:0]  r_shreg;
    logic [FRAME_BITS-1:0]  r_key;
    logic                   r_key_strobe;
    logic                   r_frame_err;

    logic w_s_sck;
    logic w_s_mosi;
    logic w_s_cs_n;
    logic w_sck_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_s_sck    = r_sck_sync[SYNC_STAGES-1];
    assign w_s_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_s_cs_n   = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_s_sck & ~r_sck_d;
    assign w_cs_fall  = ~w_s_cs_n & r_cs_d;
    assign w_cs_rise  = w_s_cs_n & ~r_cs_d;

    // cs_n resets high so that a held-low cs_n at reset release reads as a fresh frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi.key_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.key_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.key_cs_n};
            r_sck_d     <= w_s_sck;
            r_cs_d      <= w_s_cs_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_timer      <= '0;
            r_shreg      <= '0;
            r_key        <= '0;
            r_key_strobe <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_key_strobe <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                        r_timer   <= '0;
                    end
                end
                SHIFT: begin
                    // cs_rise wins over a coincident sck edge and over the timeout.
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        if (r_bit_cnt == FULL_CNT) begin
                            r_key        <= r_shreg;
                            r_key_strobe <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sck_rise) begin
                        r_timer <= '0;
                        if (r_bit_cnt < FULL_CNT) begin
                            r_shreg   <= {r_shreg[FRAME_BITS-2:0], w_s_mosi};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else begin
                            r_state <= ERR;
                        end
                    end else if (r_timer == TMO_LAST) begin
                        r_state <= ERR;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ERR: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi.key        = r_key;
    assign spi.key_strobe = r_key_strobe;
    assign spi.frame_err  = r_frame_err;
    assign spi.busy       = (r_state != IDLE);
    assign spi.dbg_state  = r_state;
endmodule

// File: tb/tb_spi_key_receiver.sv
// Directed bench for spi_key_receiver: table of whole frames plus hand sequences
// for reset mid-frame, strobe latency and back-to-back frames.
module tb_spi_key_receiver;
    localparam int SYNC_STAGES    = 2;
    localparam int FRAME_BITS     = 8;
    localparam int TIMEOUT_CYCLES = 4096;

    logic clk;
    logic rst;
    spi_key_if #(.FRAME_BITS(FRAME_BITS)) bus ();

    spi_key_receiver #(
        .SYNC_STAGES(SYNC_STAGES),
        .FRAME_BITS(FRAME_BITS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spi(bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor, sampled 1 time unit after the active edge
    int n_strobe = 0;
    int n_err = 0;
    int strobe_cyc = 0;
    always @(posedge clk) begin
        #1;
        if (bus.key_strobe === 1'b1) begin
            n_strobe++;
            strobe_cyc = cyc;
        end
        if (bus.frame_err === 1'b1) n_err++;
    end

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.key_mosi = b;
        bus.key_sck  = 1'b0;
        wait_clk(4);
        bus.key_sck  = 1'b1;
        wait_clk(4);
        bus.key_sck  = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] pat, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(pat[15-i]);
    endtask

    int cs_rise_cyc = 0;
    task automatic raise_cs();
        bus.key_cs_n = 1'b1;
        cs_rise_cyc  = cyc;
    endtask

    typedef struct {
        logic [15:0] pat;
        int          nbits;
        int          idle;
        int          exp_strobes;
        int          exp_errs;
        logic [7:0]  exp_key;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int s0, e0;
        vecs[0] = '{16'h4100, 8, 4,    1, 0, 8'h41, 2'd1};
        vecs[1] = '{16'hFE00, 7, 4,    0, 1, 8'h41, 2'd1};
        vecs[2] = '{16'hC380, 9, 4,    0, 1, 8'h41, 2'd2};
        vecs[3] = '{16'hA000, 3, TIMEOUT_CYCLES + 10, 0, 1, 8'h41, 2'd2};

        bus.key_sck  = 1'b0;
        bus.key_mosi = 1'b0;
        bus.key_cs_n = 1'b1;
        rst = 1'b1;
        #1;
        chk("reset key", 32'(bus.key), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset strobe", 32'(bus.key_strobe), 32'h0);
        chk("reset frame_err", 32'(bus.frame_err), 32'h0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);

        // table-driven frames
        for (int i = 0; i < 4; i++) begin
            s0 = n_strobe;
            e0 = n_err;
            bus.key_cs_n = 1'b0;
            wait_clk(4);
            send_bits(vecs[i].pat, vecs[i].nbits);
            wait_clk(vecs[i].idle);
            chk($sformatf("vec%0d busy_in_frame", i), 32'(bus.busy), 32'h1);
            chk($sformatf("vec%0d state_in_frame", i), 32'(bus.dbg_state), 32'(vecs[i].exp_state));
            raise_cs();
            wait_clk(10);
            chk($sformatf("vec%0d strobes", i), 32'(n_strobe - s0), 32'(vecs[i].exp_strobes));
            chk($sformatf("vec%0d frame_errs", i), 32'(n_err - e0), 32'(vecs[i].exp_errs));
            chk($sformatf("vec%0d key", i), 32'(bus.key), 32'(vecs[i].exp_key));
            chk($sformatf("vec%0d busy_after", i), 32'(bus.busy), 32'h0);
            if (vecs[i].exp_strobes == 1)
                chk($sformatf("vec%0d strobe_latency", i), 32'(strobe_cyc - cs_rise_cyc),
                    32'(SYNC_STAGES + 1));
        end

        // reset in the middle of 0xA5: the tail arrives as a short frame
        s0 = n_strobe;
        e0 = n_err;
        bus.key_cs_n = 1'b0;
        wait_clk(4);
        send_bits(16'hA500, 4);
        wait_clk(2);
        rst = 1'b1;
        #1;
        chk("midrst key_now", 32'(bus.key), 32'h0);
        chk("midrst busy_now", 32'(bus.busy), 32'h0);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        send_bits(16'h5000, 4);
        wait_clk(4);
        chk("midrst busy_tail", 32'(bus.busy), 32'h1);
        raise_cs();
        wait_clk(10);
        chk("midrst strobes", 32'(n_strobe - s0), 32'h0);
        chk("midrst frame_errs", 32'(n_err - e0), 32'h1);
        chk("midrst key", 32'(bus.key), 32'h0);

        // back-to-back 0x80 then 0x00 with a 2-clk cs_n high gap
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h00);
        s0 = n_strobe;
        e0 = n_err;
        bus.key_cs_n = 1'b0;
        wait_clk(4);
        send_bits({exp_q[0], 8'h00}, 8);
        wait_clk(4);
        raise_cs();
        wait_clk(2);
        bus.key_cs_n = 1'b0;
        wait_clk(4);
        chk("b2b key_first", 32'(bus.key), 32'(exp_q[0]));
        chk("b2b busy_second", 32'(bus.busy), 32'h1);
        send_bits({exp_q[1], 8'h00}, 8);
        wait_clk(4);
        raise_cs();
        wait_clk(10);
        chk("b2b strobes", 32'(n_strobe - s0), 32'h2);
        chk("b2b frame_errs", 32'(n_err - e0), 32'h0);
        chk("b2b key_second", 32'(bus.key), 32'(exp_q[1]));

        // key must hold between frames
        wait_clk(50);
        chk("hold key", 32'(bus.key), 32'(exp_q[1]));
        chk("hold strobes", 32'(n_strobe - s0), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
